// File: rtl/binary_target_locator_pkg.sv
// Shared constants for the binary target locator: colour modes, binarised pixel
// levels and FSM state encoding.
package binary_target_locator_pkg;

  localparam logic [1:0] MODE_RED   = 2'b00;
  localparam logic [1:0] MODE_GREEN = 2'b01;
  localparam logic [1:0] MODE_BLUE  = 2'b10;
  localparam logic [1:0] MODE_GRAY  = 2'b11;

  localparam logic [7:0] BIN_TARGET     = 8'd0;
  localparam logic [7:0] BIN_BACKGROUND = 8'd255;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACCUM   = 2'd1;
  localparam state_t ST_PUBLISH = 2'd2;

endpackage

// File: rtl/binary_target_locator_raster.sv
// Raster x/y counter. A restart forces the current coordinate to (0,0) in the same
// cycle, so a pixel coincident with the restart is processed as the first pixel.
module raster_counter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned COORD_W  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_pixel
);

  logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
  logic               x_wrap;

  always_comb begin
    x          = restart ? '0 : x_q;
    y          = restart ? '0 : y_q;
    x_wrap     = (x == COORD_W'(H_ACTIVE - 1));
    last_pixel = x_wrap && (y == COORD_W'(V_ACTIVE - 1));
    x_d        = x;
    y_d        = y;
    if (advance) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = last_pixel ? '0 : y + COORD_W'(1);
      end else begin
        x_d = x + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/binary_target_locator.sv
// Per-frame bounding box, centre and pixel count of target pixels from the
// binarisation stage; results are published with a one-cycle result_valid pulse.
module binary_target_locator
  import binary_target_locator_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned CNT_W      = 19,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [7:0]         bin,
  input  logic [1:0]         color_select,
  input  logic [7:0]         threhold,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic [CNT_W-1:0]   pix_count,
  output logic               target_found,
  output logic               result_valid
);

  state_t state_q, state_d;

  logic [COORD_W-1:0] px, py;
  logic               last_pixel, accept, frame_done, is_target, found_d;

  logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [COORD_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W:0]   sum_x, sum_y;
  logic [COORD_W-1:0] center_x_d, center_y_d;

  // frame_start opens a frame from any state, so its pixel is always accepted.
  assign accept     = pix_valid && (frame_start || (state_q == ST_ACCUM));
  assign frame_done = accept && last_pixel;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COORD_W  (COORD_W)
  ) u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (frame_start),
    .advance    (accept),
    .x          (px),
    .y          (py),
    .last_pixel (last_pixel)
  );

  always_comb begin
    if (color_select == MODE_GRAY) begin
      is_target = (bin < threhold);
    end else begin
      is_target = (bin == BIN_TARGET);
    end
  end

  always_comb begin
    if (frame_start) begin
      x_min_d = '1;
      x_max_d = '0;
      y_min_d = '1;
      y_max_d = '0;
      cnt_d   = '0;
    end else begin
      x_min_d = x_min_q;
      x_max_d = x_max_q;
      y_min_d = y_min_q;
      y_max_d = y_max_q;
      cnt_d   = cnt_q;
    end
    if (accept && is_target) begin
      if (px < x_min_d) x_min_d = px;
      if (px > x_max_d) x_max_d = px;
      if (py < y_min_d) y_min_d = py;
      if (py > y_max_d) y_max_d = py;
      if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_comb begin
    found_d    = (cnt_d >= CNT_W'(MIN_PIXELS));
    sum_x      = {1'b0, x_min_d} + {1'b0, x_max_d};
    sum_y      = {1'b0, y_min_d} + {1'b0, y_max_d};
    center_x_d = COORD_W'(sum_x >> 1);
    center_y_d = COORD_W'(sum_y >> 1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (frame_start) state_d = ST_ACCUM;
      ST_ACCUM:   state_d = ST_ACCUM;
      ST_PUBLISH: state_d = frame_start ? ST_ACCUM : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (frame_done) state_d = ST_PUBLISH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_min_q <= '1;
      x_max_q <= '0;
      y_min_q <= '1;
      y_max_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_min_q <= x_min_d;
      x_max_q <= x_max_d;
      y_min_q <= y_min_d;
      y_max_q <= y_max_d;
      cnt_q   <= cnt_d;
    end
  end

  // Results are captured on the edge accepting the last pixel, so they are
  // visible together with result_valid during the PUBLISH cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      center_x     <= '0;
      center_y     <= '0;
      pix_count    <= '0;
      target_found <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= frame_done;
      if (frame_done) begin
        pix_count    <= cnt_d;
        target_found <= found_d;
        x_min        <= found_d ? x_min_d : '0;
        x_max        <= found_d ? x_max_d : '0;
        y_min        <= found_d ? y_min_d : '0;
        y_max        <= found_d ? y_max_d : '0;
        center_x     <= found_d ? center_x_d : '0;
        center_y     <= found_d ? center_y_d : '0;
      end
    end
  end

endmodule

// File: tb/tb_binary_target_locator.sv
// Directed bench for binary_target_locator on a 16x8 raster: table-driven frames
// plus hand sequences for abort, blanking and mid-frame reset.
module tb_binary_target_locator;

  localparam int H    = 16;
  localparam int V    = 8;
  localparam int CW   = 4;
  localparam int NW   = 8;
  localparam int MINP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic          pix_valid;
  logic [7:0]    bin;
  logic [1:0]    color_select;
  logic [7:0]    threhold;
  logic [CW-1:0] x_min, x_max, y_min, y_max, center_x, center_y;
  logic [NW-1:0] pix_count;
  logic          target_found;
  logic          result_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] thr;
    int         pat;
    bit         gaps;
    bit         lone;
    int         xmin, xmax, ymin, ymax, cx, cy, cnt;
    bit         found;
  } vec_t;

  vec_t vecs[7];

  binary_target_locator #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .COORD_W    (CW),
    .CNT_W      (NW),
    .MIN_PIXELS (MINP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .bin          (bin),
    .color_select (color_select),
    .threhold     (threhold),
    .x_min        (x_min),
    .x_max        (x_max),
    .y_min        (y_min),
    .y_max        (y_max),
    .center_x     (center_x),
    .center_y     (center_y),
    .pix_count    (pix_count),
    .target_found (target_found),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0: rectangle x 3..6, y 2..4; 1: three pixels on row 1; 2: gray single at (5,5);
  // 3: the four raster corners.
  function automatic logic [7:0] pix_val(input int pat, input int x, input int y);
    case (pat)
      0: return (x >= 3 && x <= 6 && y >= 2 && y <= 4) ? 8'd0 : 8'd255;
      1: return (y == 1 && x >= 1 && x <= 3) ? 8'd0 : 8'd255;
      2: return (x == 5 && y == 5) ? 8'd127 : 8'd128;
      3: return ((x == 0 || x == H - 1) && (y == 0 || y == V - 1)) ? 8'd0 : 8'd255;
      default: return 8'd255;
    endcase
  endfunction

  task automatic drive_frame(input logic [1:0] mode, input logic [7:0] thr, input int pat,
                             input bit gaps, input bit lone, input int n_pix,
                             output int early, output bit rv_last);
    early        = 0;
    rv_last      = 1'b0;
    color_select = mode;
    threhold     = thr;
    if (lone) begin
      frame_start = 1'b1;
      pix_valid   = 1'b0;
      @(negedge clk);
      early += int'(result_valid);
    end
    for (int idx = 0; idx < n_pix; idx++) begin
      frame_start = !lone && (idx == 0);
      pix_valid   = 1'b1;
      bin         = pix_val(pat, idx % H, idx / H);
      @(negedge clk);
      frame_start = 1'b0;
      if (idx == H * V - 1) rv_last = result_valid;
      else early += int'(result_valid);
      if (gaps && idx < n_pix - 1) begin
        pix_valid = 1'b0;
        bin       = 8'd0;
        repeat (2) begin
          @(negedge clk);
          early += int'(result_valid);
        end
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, " x_min"}, 32'(x_min), v.xmin);
    check({tag, " x_max"}, 32'(x_max), v.xmax);
    check({tag, " y_min"}, 32'(y_min), v.ymin);
    check({tag, " y_max"}, 32'(y_max), v.ymax);
    check({tag, " center_x"}, 32'(center_x), v.cx);
    check({tag, " center_y"}, 32'(center_y), v.cy);
    check({tag, " pix_count"}, 32'(pix_count), v.cnt);
    check({tag, " target_found"}, 32'(target_found), 32'(v.found));
  endtask

  task automatic check_zero(input string tag);
    vec_t z;
    z = '{2'b00, 8'd0, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0};
    check_result(tag, z);
    check({tag, " result_valid"}, 32'(result_valid), 0);
  endtask

  initial begin
    int   early;
    bit   rv_last;
    int   pulses;
    vec_t corners;

    //         mode   thr     pat gaps lone xmin xmax ymin ymax cx cy cnt found
    vecs[0] = '{2'b00, 8'd0,   0, 1'b0, 1'b0, 3, 6, 2, 4, 4, 3, 12, 1'b1};
    vecs[1] = '{2'b00, 8'd0,   1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 3,  1'b0};
    vecs[2] = '{2'b11, 8'd128, 2, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1,  1'b0};
    vecs[3] = '{2'b10, 8'd0,   3, 1'b0, 1'b0, 0, 15, 0, 7, 7, 3, 4, 1'b1};
    vecs[4] = '{2'b11, 8'd200, 0, 1'b0, 1'b0, 3, 6, 2, 4, 4, 3, 12, 1'b1};
    vecs[5] = '{2'b01, 8'd0,   2, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0,  1'b0};
    vecs[6] = '{2'b00, 8'd0,   0, 1'b1, 1'b1, 3, 6, 2, 4, 4, 3, 12, 1'b1};
    corners = vecs[3];

    rst_n        = 1'b0;
    frame_start  = 1'b0;
    pix_valid    = 1'b0;
    bin          = 8'd255;
    color_select = 2'b00;
    threhold     = 8'd0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Frames run back to back, so each new frame_start lands in the PUBLISH cycle.
    for (int i = 0; i < 7; i++) begin
      drive_frame(vecs[i].mode, vecs[i].thr, vecs[i].pat, vecs[i].gaps, vecs[i].lone, H * V,
                  early, rv_last);
      check($sformatf("vec%0d early result_valid", i), 32'(early), 0);
      check($sformatf("vec%0d result_valid latency", i), 32'(rv_last), 1);
      check_result($sformatf("vec%0d", i), vecs[i]);
    end

    // Outputs hold while idle.
    repeat (3) @(negedge clk);
    check("hold result_valid", 32'(result_valid), 0);
    check("hold pix_count", 32'(pix_count), 12);

    // Abort at pixel (4,3): that pixel becomes (0,0) of a corners frame.
    drive_frame(2'b00, 8'd0, 0, 1'b0, 1'b0, 3 * H + 4, early, rv_last);
    check("abort partial early", 32'(early), 0);
    check("abort keeps pix_count", 32'(pix_count), 12);
    drive_frame(2'b00, 8'd0, 3, 1'b0, 1'b0, H * V, early, rv_last);
    check("abort no stale result_valid", 32'(early), 0);
    check("abort result_valid latency", 32'(rv_last), 1);
    check_result("abort", corners);

    // Reset for one cycle mid-frame, then target pixels without frame_start.
    drive_frame(2'b00, 8'd0, 0, 1'b0, 1'b0, 40, early, rv_last);
    rst_n     = 1'b0;
    pix_valid = 1'b1;
    bin       = 8'd0;
    @(negedge clk);
    check_zero("midreset");
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 2 * H * V; c++) begin
      @(negedge clk);
      pulses += int'(result_valid);
    end
    pix_valid = 1'b0;
    check("idle ignores pixels result_valid", 32'(pulses), 0);
    check("idle ignores pixels pix_count", 32'(pix_count), 0);
    drive_frame(2'b00, 8'd0, 0, 1'b0, 1'b0, H * V, early, rv_last);
    check("post-reset result_valid latency", 32'(rv_last), 1);
    check_result("post-reset", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
